// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer: PC, IR latch, J/IN/HLT handling, datapath handshake
module instr_fetch_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addy,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              in_valid,
  output logic              in_wait,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [5:0] OP_IN  = 6'b010101;
  localparam logic [5:0] OP_J   = 6'b010111;
  localparam logic [5:0] OP_HLT = 6'b011000;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    IO_WAIT = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [DATA_W-1:0] ir_n;
  logic              ir_valid_n;
  logic              in_wait_n;
  logic              halted_n;
  logic [5:0]        opcode;

  // The memory is asynchronous-read, so the address is simply the PC.
  assign mem_addy = pc;
  assign opcode   = mem_data[DATA_W-1 -: 6];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Program counter, instruction register and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= PC_INIT;
      ir       <= '0;
      ir_valid <= 1'b0;
      in_wait  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc       <= pc_n;
      ir       <= ir_n;
      ir_valid <= ir_valid_n;
      in_wait  <= in_wait_n;
      halted   <= halted_n;
    end
  end

  // Next-state and register-update decode; everything holds unless a state acts on it.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_valid_n = ir_valid;
    in_wait_n  = in_wait;
    halted_n   = halted;

    case (state)
      IDLE: begin
        if (run) begin
          state_n = FETCH;
        end
      end

      FETCH: begin
        // Dropping run parks the fetcher here without touching pc or ir.
        if (run) begin
          ir_n = mem_data;
          case (opcode)
            OP_HLT: begin
              state_n  = HALT;
              halted_n = 1'b1;
            end
            OP_J: begin
              // Jumps are resolved here and never reach the datapath.
              pc_n    = mem_data[ADDR_W-1:0];
              state_n = FETCH;
            end
            OP_IN: begin
              state_n   = IO_WAIT;
              in_wait_n = 1'b1;
            end
            default: begin
              state_n    = EXEC;
              ir_valid_n = 1'b1;
            end
          endcase
        end
      end

      IO_WAIT: begin
        // Operator entry releases the stall regardless of run.
        if (in_valid) begin
          state_n    = EXEC;
          ir_valid_n = 1'b1;
          in_wait_n  = 1'b0;
        end
      end

      EXEC: begin
        if (exec_done) begin
          ir_valid_n = 1'b0;
          pc_n       = branch_taken ? branch_target : pc + ADDR_W'(1);
          state_n    = FETCH;
        end
      end

      HALT: begin
        state_n = HALT;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
